doppler_bin_search: RTL and testbench

//  Carrier Doppler search sequencer, directly downstream of thresh_control_bhv.

---
 rtl/doppler_bin_search.sv | 107 ++++++++++
 tb/tb_doppler_bin_search.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/doppler_bin_search.sv
// Carrier Doppler search sequencer: steps the NCO frequency word through zig-zag
// Doppler bins on each synchronised car_change edge, freezing while acquired.
`timescale 1ns/1ps
module doppler_bin_search #(
    parameter int unsigned     FW        = 32,
    parameter logic [FW-1:0]   CENTER_FW = FW'(32'h4000_0000),
    parameter int unsigned     BIN_STEP  = 131200,
    parameter int unsigned     NUM_BINS  = 21
) (
    input  logic          clk,
    input  logic          res,
    input  logic          car_change,
    input  logic          acq,
    input  logic          restart,
    output logic [FW-1:0] freq_word,
    output logic [7:0]    bin_offset,
    output logic          bin_step,
    output logic          sweep_done,
    output logic [7:0]    sweep_count,
    output logic          locked
);

    localparam int unsigned   MAX_OFF = (NUM_BINS - 1) / 2;
    localparam logic [7:0]    NEG_MAX = 8'(32'd0 - MAX_OFF);
    localparam logic [FW-1:0] STEP_W  = FW'(BIN_STEP);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t        state, state_next;
    logic          s1, s2, s3;
    logic          step_req_c;
    logic          wrap_c;
    logic [7:0]    off_step_c;
    logic [FW-1:0] freq_step_c;

    logic [FW-1:0] freq_next;
    logic [7:0]    off_next;
    logic          bin_step_next;
    logic          sweep_done_next;
    logic [7:0]    count_next;

    assign step_req_c = s2 & ~s3;

    // Zig-zag successor of the current bin: 0,+1,-1,+2,-2,...,-M, then back to 0
    always_comb begin
        wrap_c     = 1'b0;
        off_step_c = 8'd0;
        if (bin_offset == NEG_MAX) begin
            wrap_c = 1'b1;
        end else if (!bin_offset[7] && bin_offset != 8'd0) begin
            off_step_c = 8'd0 - bin_offset;
        end else begin
            off_step_c = 8'd1 - bin_offset;
        end
    end

    // Sign-extended offset times bin step; wraps modulo 2^FW by construction
    assign freq_step_c = CENTER_FW + ({{(FW-8){off_step_c[7]}}, off_step_c} * STEP_W);

    always_comb begin
        state_next      = acq ? LOCKED : SEARCH;
        freq_next       = freq_word;
        off_next        = bin_offset;
        bin_step_next   = 1'b0;
        sweep_done_next = 1'b0;
        count_next      = sweep_count;
        if (restart) begin
            freq_next = CENTER_FW;
            off_next  = 8'd0;
        end else if (state == SEARCH && !acq && step_req_c) begin
            freq_next       = freq_step_c;
            off_next        = off_step_c;
            bin_step_next   = 1'b1;
            sweep_done_next = wrap_c;
            if (wrap_c && sweep_count != 8'hFF) begin
                count_next = sweep_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state       <= SEARCH;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            freq_word   <= CENTER_FW;
            bin_offset  <= 8'd0;
            bin_step    <= 1'b0;
            sweep_done  <= 1'b0;
            sweep_count <= 8'd0;
            locked      <= 1'b0;
        end else begin
            state       <= state_next;
            s1          <= car_change;
            s2          <= s1;
            s3          <= s2;
            freq_word   <= freq_next;
            bin_offset  <= off_next;
            bin_step    <= bin_step_next;
            sweep_done  <= sweep_done_next;
            sweep_count <= count_next;
            locked      <= (state_next == LOCKED);
        end
    end

endmodule

// File: tb/tb_doppler_bin_search.sv
// Bench for doppler_bin_search: directed sequence with randomized pulse widths,
// checked against a sweep-index model of the zig-zag bin order.
`timescale 1ns/1ps
module tb_doppler_bin_search;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        car_change = 1'b0;
    logic        acq = 1'b0;
    logic        restart = 1'b0;
    logic [31:0] freq_word;
    logic [7:0]  bin_offset;
    logic        bin_step;
    logic        sweep_done;
    logic [7:0]  sweep_count;
    logic        locked;

    int checks = 0;
    int failures = 0;
    int k = 0;
    int sc = 0;
    int bs_cnt = 0;
    int sd_cnt = 0;

    doppler_bin_search dut (
        .clk(clk), .res(res), .car_change(car_change), .acq(acq), .restart(restart),
        .freq_word(freq_word), .bin_offset(bin_offset), .bin_step(bin_step),
        .sweep_done(sweep_done), .sweep_count(sweep_count), .locked(locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (bin_step) bs_cnt++;
        if (sweep_done) sd_cnt++;
    end

    function automatic int zz(int idx);
        if (idx == 0) return 0;
        if (idx % 2 == 1) return (idx + 1) / 2;
        return -(idx / 2);
    endfunction

    function automatic logic [31:0] efreq(int off);
        longint f;
        f = 64'sh4000_0000 + longint'(off) * 64'sd131200;
        return f[31:0];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bin(string tag);
        logic [7:0] eo;
        eo = 8'(zz(k));
        chk({tag, "_offset"}, 32'(bin_offset), 32'(eo));
        chk({tag, "_freq"}, freq_word, efreq(zz(k)));
    endtask

    task automatic advance();
        k = (k + 1) % 21;
        if (k == 0 && sc < 255) sc++;
    endtask

    // One car_change pulse of `hold` cycles; step lands on the third sampling edge
    task automatic do_pulse(int hold, bit full);
        bit wrap;
        wrap = 1'b0;
        @(negedge clk) car_change = 1'b1;
        for (int c = 1; c <= hold + 4; c++) begin
            @(negedge clk);
            if (c == hold) car_change = 1'b0;
            if (c == 3) begin
                wrap = (k == 20);
                advance();
            end
            if (full) begin
                if (c == 2) check_bin("pre_step");
                if (c == 3) begin
                    chk("bin_step_edge3", 32'(bin_step), 32'd1);
                    chk("sweep_done_edge3", 32'(sweep_done), 32'(wrap));
                    chk("sweep_count_step", 32'(sweep_count), 32'(sc));
                    check_bin("post_step");
                end else begin
                    chk("bin_step_idle", 32'(bin_step), 32'd0);
                    chk("sweep_done_idle", 32'(sweep_done), 32'd0);
                end
            end
        end
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_freq"}, freq_word, 32'h4000_0000);
        chk({tag, "_offset"}, 32'(bin_offset), 32'd0);
        chk({tag, "_bin_step"}, 32'(bin_step), 32'd0);
        chk({tag, "_sweep_done"}, 32'(sweep_done), 32'd0);
        chk({tag, "_sweep_count"}, 32'(sweep_count), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic do_reset();
        #3 res = 1'b0;
        car_change = 1'b0;
        acq = 1'b0;
        restart = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        @(negedge clk) res = 1'b1;
        k = 0;
        sc = 0;
    endtask

    initial begin
        int bs0;
        int sd0;
        logic [7:0] eo;

        // Power-on reset
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        res = 1'b1;
        @(negedge clk);

        // Four pulses with explicit frequency words
        do_pulse(int'($urandom_range(1, 6)), 1'b1);
        chk("p1_freq", freq_word, 32'h4002_0080);
        do_pulse(int'($urandom_range(1, 6)), 1'b1);
        chk("p2_freq", freq_word, 32'h3FFD_FF80);
        do_pulse(int'($urandom_range(1, 6)), 1'b1);
        chk("p3_freq", freq_word, 32'h4004_0100);
        do_pulse(int'($urandom_range(1, 6)), 1'b1);
        chk("p4_freq", freq_word, 32'h3FFB_FF00);
        chk("p4_offset", 32'(bin_offset), 32'h0000_00FE);

        // Level held high for 100 cycles yields one step
        bs0 = bs_cnt;
        @(negedge clk) car_change = 1'b1;
        repeat (100) @(negedge clk);
        car_change = 1'b0;
        repeat (5) @(negedge clk);
        advance();
        chk("hold_one_step", 32'(bs_cnt - bs0), 32'd1);
        check_bin("hold");

        // Reset in the middle of a sweep
        do_reset();
        @(negedge clk);
        check_reset_vals("post_reset");

        // One full sweep, then saturate the sweep counter
        sd0 = sd_cnt;
        for (int i = 0; i < 21; i++) do_pulse(int'($urandom_range(1, 4)), 1'b1);
        chk("sweep1_count", 32'(sweep_count), 32'd1);
        chk("sweep1_done_pulses", 32'(sd_cnt - sd0), 32'd1);
        for (int i = 0; i < 255 * 21; i++) do_pulse(1, 1'b0);
        chk("sat_count", 32'(sweep_count), 32'd255);
        chk("sat_model", 32'(sweep_count), 32'(sc));
        chk("sat_done_pulses", 32'(sd_cnt - sd0), 32'd256);
        check_bin("sat_end");

        // Acquisition freeze, including acq rising with step_req
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) do_pulse(int'($urandom_range(1, 5)), 1'b1);
        bs0 = bs_cnt;
        @(negedge clk) car_change = 1'b1;
        @(negedge clk);
        @(negedge clk) begin acq = 1'b1; car_change = 1'b0; end
        @(negedge clk);
        chk("acq_same_cycle_locked", 32'(locked), 32'd1);
        chk("acq_same_cycle_freq", freq_word, 32'h4004_0100);
        chk("acq_same_cycle_bin_step", 32'(bin_step), 32'd0);
        repeat (4) @(negedge clk);
        car_change = 1'b1;
        repeat (6) @(negedge clk);
        car_change = 1'b0;
        repeat (5) @(negedge clk);
        chk("locked_no_steps", 32'(bs_cnt - bs0), 32'd0);
        chk("locked_freq_held", freq_word, 32'h4004_0100);
        chk("locked_hold", 32'(locked), 32'd1);
        acq = 1'b0;
        @(negedge clk);
        chk("unlocked", 32'(locked), 32'd0);
        do_pulse(int'($urandom_range(1, 5)), 1'b1);
        eo = 8'hFE;
        chk("resume_offset", 32'(bin_offset), 32'(eo));

        // Restart at -3, and restart coinciding with step_req
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) do_pulse(int'($urandom_range(1, 5)), 1'b0);
        check_bin("at_minus3");
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
        k = 0;
        check_bin("restart");
        chk("restart_bin_step", 32'(bin_step), 32'd0);
        chk("restart_sweep_done", 32'(sweep_done), 32'd0);
        chk("restart_sweep_count", 32'(sweep_count), 32'(sc));
        do_pulse(2, 1'b0);
        do_pulse(2, 1'b0);
        bs0 = bs_cnt;
        @(negedge clk) car_change = 1'b1;
        @(negedge clk);
        @(negedge clk) begin restart = 1'b1; car_change = 1'b0; end
        @(negedge clk) restart = 1'b0;
        k = 0;
        check_bin("restart_vs_step");
        chk("restart_vs_step_bin_step", 32'(bs_cnt - bs0), 32'd0);
        chk("restart_vs_step_sweep_done", 32'(sweep_done), 32'd0);
        repeat (4) @(negedge clk);
        do_pulse(int'($urandom_range(1, 5)), 1'b1);
        chk("after_restart_offset", 32'(bin_offset), 32'd1);
        chk("after_restart_freq", freq_word, 32'h4002_0080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
